// File: rtl/counter_pkg.sv
// Shared types for the generic up/down counter.
// Holds the terminal-behaviour mode and the run/halt state encodings.
package counter_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2,
        RELOAD  = 2'd3
    } mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/gen_counter.sv
// Generic up/down counter with selectable terminal behaviour
// (wrap, saturate, one-shot halt, reload from last loaded value).
//
// Ports:
//   clk     : clock, all state changes on rising edge
//   rst     : synchronous active-high reset
//   data    : load value (clamped to MAX_VAL)
//   load    : load strobe, beats enable
//   enable  : step strobe, ignored while halted
//   up      : 1 = count up, 0 = count down
//   mode    : terminal behaviour (mode_t)
//   count   : registered counter value
//   tc      : registered one-cycle terminal-event pulse
//   done    : registered, high while halted
module gen_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  mode_t            mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_done;
    logic             r_sat_flag;
    mode_t            r_mode;
    cnt_state_t       r_state;

    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_term_val;
    logic [WIDTH-1:0] w_step_val;
    logic             w_at_term;
    logic             w_mode_chg;
    logic             w_sat_flag;
    logic             w_step;

    always_comb begin
        w_load_val = (data > MAX_VAL) ? MAX_VAL : data;
        w_term_val = up ? MAX_VAL : '0;
        w_at_term  = (r_count == w_term_val);
        w_step_val = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
        // r_mode holds last cycle's mode; any difference drops the
        // saturate first-block flag so the next blocked step pulses again.
        w_mode_chg = (mode != r_mode);
        w_sat_flag = r_sat_flag && !w_mode_chg;
        w_step     = enable && (r_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_reload   <= '0;
            r_tc       <= 1'b0;
            r_done     <= 1'b0;
            r_sat_flag <= 1'b0;
            r_mode     <= mode;
            r_state    <= RUN;
        end else begin
            r_mode     <= mode;
            r_tc       <= 1'b0;
            r_sat_flag <= w_sat_flag;
            if (load) begin
                r_count    <= w_load_val;
                r_reload   <= w_load_val;
                r_sat_flag <= 1'b0;
                r_state    <= RUN;
                r_done     <= 1'b0;
            end else if (w_step) begin
                if (!w_at_term) begin
                    r_count    <= w_step_val;
                    r_sat_flag <= 1'b0;
                end else begin
                    unique case (mode)
                        FREE: begin
                            r_count <= up ? '0 : MAX_VAL;
                            r_tc    <= 1'b1;
                        end
                        SAT: begin
                            // Pulse only on the first blocked step.
                            r_tc       <= !w_sat_flag;
                            r_sat_flag <= 1'b1;
                        end
                        ONESHOT: begin
                            r_tc    <= 1'b1;
                            r_state <= HALT;
                            r_done  <= 1'b1;
                        end
                        RELOAD: begin
                            r_count <= r_reload;
                            r_tc    <= 1'b1;
                        end
                        default: begin
                            r_tc <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign done  = r_done;

endmodule

// File: tb/tb_gen_counter.sv
// Scoreboard bench for gen_counter (WIDTH=4, MAX_VAL=9): directed
// scenarios plus random stimulus against a behavioural model.
module tb_gen_counter;
    import counter_pkg::*;

    localparam int W   = 4;
    localparam int MAX = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data;
    logic         load;
    logic         enable;
    logic         up;
    mode_t        mode;
    logic [W-1:0] count;
    logic         tc;
    logic         done;

    gen_counter #(.WIDTH(W), .MAX_VAL(W'(MAX))) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .load   (load),
        .enable (enable),
        .up     (up),
        .mode   (mode),
        .count  (count),
        .tc     (tc),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit t;
        bit d;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    int m_cnt    = 0;
    int m_reload = 0;
    bit m_halt   = 0;
    bit m_blocked = 0;
    int m_last_mode = 0;
    bit m_tc     = 0;

    function automatic void model(bit r, bit ld, int d, bit en, bit u, int md);
        if (r) begin
            m_cnt = 0; m_reload = 0; m_halt = 0;
            m_blocked = 0; m_tc = 0;
        end else begin
            if (md != m_last_mode) m_blocked = 0;
            m_tc = 0;
            if (ld) begin
                m_cnt = (d > MAX) ? MAX : d;
                m_reload = m_cnt;
                m_halt = 0;
                m_blocked = 0;
            end else if (en && !m_halt) begin
                if (u ? (m_cnt != MAX) : (m_cnt != 0)) begin
                    m_cnt = u ? m_cnt + 1 : m_cnt - 1;
                    m_blocked = 0;
                end else begin
                    case (md)
                        0: begin m_cnt = u ? 0 : MAX; m_tc = 1; end
                        1: begin m_tc = !m_blocked; m_blocked = 1; end
                        2: begin m_tc = 1; m_halt = 1; end
                        default: begin m_cnt = m_reload; m_tc = 1; end
                    endcase
                end
            end
        end
        m_last_mode = md;
    endfunction

    task automatic cyc(bit r, bit ld, int d, bit en, bit u, int md);
        exp_t e;
        @(negedge clk);
        rst = r; load = ld; data = W'(d);
        enable = en; up = u; mode = mode_t'(md);
        model(r, ld, d, en, u, md);
        e.c = m_cnt; e.t = m_tc; e.d = m_halt;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (int'(count) != e.c) begin
                    errors++;
                    $display("FAIL count: got %0d want %0d @%0t", count, e.c, $time);
                end
                checks++;
                if (tc != e.t) begin
                    errors++;
                    $display("FAIL tc: got %0b want %0b @%0t", tc, e.t, $time);
                end
                checks++;
                if (done != e.d) begin
                    errors++;
                    $display("FAIL done: got %0b want %0b @%0t", done, e.d, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; load = 0; data = 0; enable = 0; up = 1; mode = FREE;
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        // FREE up wrap
        cyc(0, 1, 7, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        // SAT down, repeated blocked steps, clamp on load
        cyc(0, 1, 2, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 15, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        // ONESHOT halt then resume
        cyc(0, 1, 8, 0, 1, 2);
        repeat (4) cyc(0, 0, 0, 1, 1, 2);
        cyc(0, 1, 3, 0, 1, 2);
        repeat (2) cyc(0, 0, 0, 1, 1, 2);
        // RELOAD down
        cyc(0, 1, 3, 0, 0, 3);
        repeat (9) cyc(0, 0, 0, 1, 0, 3);
        // load and enable together
        cyc(0, 1, 5, 1, 1, 0);
        // rst overrides load; reload register cleared
        cyc(1, 1, 6, 1, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 3);
        // rst while halted
        cyc(0, 1, 9, 0, 1, 2);
        repeat (2) cyc(0, 0, 0, 1, 1, 2);
        cyc(1, 0, 0, 1, 1, 2);
        // SAT flag cleared by mode change
        cyc(0, 1, 9, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 1, 1);
        // Random
        begin
            bit u = 1;
            int md = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) u = ~u;
                if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 3);
                cyc($urandom_range(0, 59) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 15),
                    $urandom_range(0, 3) != 0,
                    u, md);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
